// File: rtl/and_n.sv
// and_n: parameterized N-input AND reduction.
// The combinational result y is built as a balanced binary tree of 2-input
// AND gates. y_q is a flopped copy of y, cleared asynchronously by rst_aL.
module and_n #(
    parameter int N_INS = 2    // number of input bits to reduce, 1..64
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic [N_INS-1:0] a,
    output logic             y,
    output logic             y_q
);

    // Number of tree nodes at level lvl. Level 0 holds the inputs and each
    // level halves the count, rounding up. The odd node left over passes through.
    function automatic int level_nodes(input int lvl);
        return (N_INS + (1 << lvl) - 1) >> lvl;
    endfunction

    // Position of the first node of level lvl in the flat node vector.
    function automatic int level_offset(input int lvl);
        int sum;
        sum = 0;
        for (int k = 0; k < lvl; k++) begin
            sum += level_nodes(k);
        end
        return sum;
    endfunction

    // The tree has ceil(log2(N_INS)) gate levels. N_INS = 1 gives zero levels.
    localparam int LEVELS = $clog2(N_INS);
    // Node count summed over every level, including the inputs and the root.
    localparam int TOTAL  = level_offset(LEVELS + 1);

    // All tree nodes packed level after level. The root is the last bit.
    logic [TOTAL-1:0] node;

    assign node[N_INS-1:0] = a;

    genvar l, j;
    for (l = 0; l < LEVELS; l++) begin : g_level
        for (j = 0; j < level_nodes(l + 1); j++) begin : g_node
            localparam int SRC = level_offset(l) + 2 * j;
            localparam int DST = level_offset(l + 1) + j;
            if (2 * j + 1 < level_nodes(l)) begin : g_and
                // Paired nodes: a single 2-input AND gate.
                assign node[DST] = node[SRC] & node[SRC + 1];
            end else begin : g_pass
                // Unpaired last node: passed unchanged to the next level.
                assign node[DST] = node[SRC];
            end
        end
    end

    // The root of the tree is the reduction result. rst_aL has no effect on it.
    assign y = node[TOTAL-1];

    // Registered copy of y. Reset clears it at once, without waiting for clk.
    always_ff @(posedge clk or negedge rst_aL) begin
        // NOTE: flops take non-blocking assignments, so every flop samples
        // its pre-edge input even when that input changes at the same edge.
        if (!rst_aL) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_and_n.sv
// tb_and_n: scoreboard bench for and_n. It covers four widths (1, 2, 5, 8).
// Stimulus pushes the expected values into a queue. A separate monitor
// process pops each entry and compares it against the DUT outputs.
module tb_and_n;

    typedef struct {
        string       name;
        int          inst;    // 0:N=1  1:N=2  2:N=5  3:N=8
        bit          is_q;    // 0 checks y, 1 checks y_q
        logic [63:0] a_val;
        logic        expect_val;
    } check_t;

    logic       clk;
    logic       rst_aL;
    logic [0:0] a1;
    logic [1:0] a2;
    logic [4:0] a5;
    logic [7:0] a8;
    logic       y1, y2, y5, y8;
    logic       yq1, yq2, yq5, yq8;

    int errors = 0;
    int checks = 0;

    check_t      sb_q[$];
    event        sample_ev;
    int          width [4] = '{1, 2, 5, 8};
    logic [63:0] cur_a [4];
    bit          in_reset;

    and_n #(.N_INS(1)) u_n1 (.clk(clk), .rst_aL(rst_aL), .a(a1), .y(y1), .y_q(yq1));
    and_n #(.N_INS(2)) u_n2 (.clk(clk), .rst_aL(rst_aL), .a(a2), .y(y2), .y_q(yq2));
    and_n #(.N_INS(5)) u_n5 (.clk(clk), .rst_aL(rst_aL), .a(a5), .y(y5), .y_q(yq5));
    and_n #(.N_INS(8)) u_n8 (.clk(clk), .rst_aL(rst_aL), .a(a8), .y(y8), .y_q(yq8));

    // Clock with a 40-unit period. Rising edges fall at 20 + 40k.
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Mask of the low w bits.
    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference model: the result is 1 exactly when every one of the w operand bits is 1.
    function automatic logic golden(input int w, input logic [63:0] v);
        return ((v & mask_of(w)) == mask_of(w)) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic dut_out(input int inst, input bit is_q);
        case (inst)
            0:       return is_q ? yq1 : y1;
            1:       return is_q ? yq2 : y2;
            2:       return is_q ? yq5 : y5;
            default: return is_q ? yq8 : y8;
        endcase
    endfunction

    task automatic set_a(input int inst, input logic [63:0] v);
        cur_a[inst] = v & mask_of(width[inst]);
        case (inst)
            0:       a1 = v[0:0];
            1:       a2 = v[1:0];
            2:       a5 = v[4:0];
            default: a8 = v[7:0];
        endcase
    endtask

    // Queue the expected y for one instance from its recorded operand.
    task automatic expect_y(input string name, input int inst);
        check_t c;
        c.name = name; c.inst = inst; c.is_q = 1'b0; c.a_val = cur_a[inst];
        c.expect_val = golden(width[inst], cur_a[inst]);
        sb_q.push_back(c);
    endtask

    // Queue the expected y_q: 0 under reset, else the result for the operand held over the last edge.
    task automatic expect_yq(input string name, input int inst);
        check_t c;
        c.name = name; c.inst = inst; c.is_q = 1'b1; c.a_val = cur_a[inst];
        c.expect_val = in_reset ? 1'b0 : golden(width[inst], cur_a[inst]);
        sb_q.push_back(c);
    endtask

    task automatic sample_now();
        -> sample_ev;
        #1;
    endtask

    // Drive operands at a falling edge. Check y after 10 units, then y_q after the next rising edge.
    task automatic apply(input string name, input int inst, input logic [63:0] v);
        @(negedge clk);
        set_a(inst, v);
        #10;
        expect_y(name, inst);
        sample_now();
        @(posedge clk);
        #1;
        expect_yq({name, "_q"}, inst);
        sample_now();
    endtask

    // Monitor: on each sample strobe, pop the queued expectations and compare them.
    initial begin
        check_t c;
        logic   act;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                c   = sb_q.pop_front();
                act = dut_out(c.inst, c.is_q);
                checks++;
                if (act !== c.expect_val) begin
                    errors++;
                    $display("FAIL %s: N_INS=%0d a=%h %s_dut=%b %s_golden=%b", c.name,
                             width[c.inst], c.a_val, c.is_q ? "y_q" : "y", act,
                             c.is_q ? "y_q" : "y", c.expect_val);
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        rst_aL   = 1'b0;
        in_reset = 1'b1;
        for (int i = 0; i < 4; i++) set_a(i, 64'd0);

        // Reset state: y_q is 0 and y tracks a while reset is held.
        #5;
        for (int i = 0; i < 4; i++) begin
            expect_yq("reset_yq", i);
            expect_y("reset_y", i);
        end
        sample_now();
        set_a(3, 64'hFF);
        #10;
        expect_y("reset_y_tracks", 3);
        expect_yq("reset_yq_held", 3);
        sample_now();

        // Release reset between edges.
        @(negedge clk);
        rst_aL   = 1'b1;
        in_reset = 1'b0;

        // Directed patterns.
        apply("all_ones_n8", 3, 64'hFF);
        apply("all_zero_n8", 3, 64'h00);
        apply("half_F0_n8",  3, 64'hF0);
        apply("half_0F_n8",  3, 64'h0F);
        apply("all_ones_n2", 1, 64'h3);
        apply("half_10_n2",  1, 64'h2);
        apply("half_01_n2",  1, 64'h1);
        apply("all_zero_n2", 1, 64'h0);
        apply("n1_one",      0, 64'h1);
        apply("n1_zero",     0, 64'h0);
        apply("all_ones_n5", 2, 64'h1F);
        for (int b = 0; b < 5; b++) begin
            apply($sformatf("n5_clear_bit%0d", b), 2, 64'h1F & ~(64'd1 << b));
        end
        apply("all_zero_n5", 2, 64'h00);

        // Randomized operands. Some iterations force all ones so the 1 case also occurs.
        for (int it = 0; it < 100; it++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) == 0) set_a(i, {64{1'b1}});
                else                        set_a(i, {$urandom, $urandom});
            end
            #10;
            for (int i = 0; i < 4; i++) expect_y($sformatf("rand%0d_y", it), i);
            sample_now();
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) expect_yq($sformatf("rand%0d_yq", it), i);
            sample_now();
        end

        // Mid-operation reset: y_q = 1, then assert rst_aL between edges.
        apply("pre_reset_ones", 3, 64'hFF);
        @(negedge clk);
        rst_aL   = 1'b0;
        in_reset = 1'b1;
        #1;
        expect_yq("async_reset_yq", 3);
        expect_y("async_reset_y", 3);
        sample_now();
        @(posedge clk);
        #1;
        expect_yq("reset_holds_yq", 3);
        sample_now();
        @(negedge clk);
        rst_aL = 1'b1;
        #5;
        expect_yq("release_no_edge_yq", 3);
        sample_now();
        in_reset = 1'b0;
        @(posedge clk);
        #1;
        expect_yq("release_first_edge_yq", 3);
        sample_now();

        // Bounded drain of the scoreboard before the summary.
        for (int t = 0; t < 100 && sb_q.size() > 0; t++) begin
            sample_now();
        end
        if (sb_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: pending=%0d required=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
